// File: rtl/rename_register_file.sv
// Rename register file: architectural registers tagged with the ROB entry
// that will produce their next value.
// Each entry holds {valid, tag, data}. valid=1 means data is usable; valid=0
// means the consumer must wait on tag.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   flush         : ROB flush; clears every outstanding rename
//   we_d/wa_d/tag_d : dispatch rename (destination register and ROB tag)
//   we_w/wa_w/tag_w/wd_w : NWB commit ports, packed per port;
//                          the higher index is the younger commit
//   ra / rd       : NRD read ports; rd per port = {valid, tag, data}
//   pending       : registered count of nonzero registers awaiting a commit
module rename_register_file #(
    parameter int unsigned DATA = 32,
    parameter int unsigned ADDR = 5,
    parameter int unsigned TAG  = 7,
    parameter int unsigned NRD  = 4,
    parameter int unsigned NWB  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         we_d,
    input  logic [ADDR-1:0]              wa_d,
    input  logic [TAG-1:0]               tag_d,
    input  logic [NWB-1:0]               we_w,
    input  logic [NWB*ADDR-1:0]          wa_w,
    input  logic [NWB*TAG-1:0]           tag_w,
    input  logic [NWB*DATA-1:0]          wd_w,
    input  logic [NRD*ADDR-1:0]          ra,
    output logic [NRD*(1+TAG+DATA)-1:0]  rd,
    output logic [ADDR:0]                pending
);

    localparam int unsigned NREG = 1 << ADDR;
    localparam int unsigned ENT  = 1 + TAG + DATA;

    logic [NREG-1:0] valid_q;
    logic [NREG-1:0] valid_n;
    logic [TAG-1:0]  tag_q  [NREG];
    logic [TAG-1:0]  tag_n  [NREG];
    logic [DATA-1:0] data_q [NREG];
    logic [DATA-1:0] data_n [NREG];
    logic [ADDR:0]   pending_n;

    logic [ADDR-1:0] rd_addr [NRD];
    logic            rd_hit  [NRD];
    logic [DATA-1:0] rd_byp  [NRD];

    // Next-state entries. Register 0 is never touched so it stays {1,0,0}.
    // Commit validity is judged against the stored (pre-dispatch) tag;
    // a same-cycle dispatch then overrides valid/tag but keeps commit data.
    always_comb begin
        valid_n = valid_q;
        tag_n   = tag_q;
        data_n  = data_q;
        for (int i = 1; i < int'(NREG); i++) begin
            for (int k = 0; k < int'(NWB); k++) begin
                if (we_w[k] && (wa_w[k*ADDR +: ADDR] == ADDR'(i))) begin
                    data_n[i] = wd_w[k*DATA +: DATA];
                    if (tag_w[k*TAG +: TAG] == tag_q[i]) begin
                        valid_n[i] = 1'b1;
                    end
                end
            end
            if (flush) begin
                valid_n[i] = 1'b1;
                tag_n[i]   = '0;
            end else if (we_d && (wa_d == ADDR'(i))) begin
                valid_n[i] = 1'b0;
                tag_n[i]   = tag_d;
            end
        end
    end

    // Outstanding-rename count over the next-state entries, saturating.
    always_comb begin
        pending_n = '0;
        for (int i = 1; i < int'(NREG); i++) begin
            if (!valid_n[i] && (pending_n != (ADDR+1)'(NREG - 1))) begin
                pending_n = pending_n + (ADDR+1)'(1);
            end
        end
    end

    // Combinational reads with commit bypass; same-cycle dispatch is not visible.
    always_comb begin
        rd = '0;
        for (int j = 0; j < int'(NRD); j++) begin
            rd_addr[j] = ra[j*ADDR +: ADDR];
            rd_hit[j]  = 1'b0;
            rd_byp[j]  = data_q[rd_addr[j]];
            for (int k = 0; k < int'(NWB); k++) begin
                if (we_w[k] && (rd_addr[j] != '0) &&
                    (wa_w[k*ADDR +: ADDR] == rd_addr[j]) &&
                    (tag_w[k*TAG +: TAG] == tag_q[rd_addr[j]])) begin
                    rd_hit[j] = 1'b1;
                    rd_byp[j] = wd_w[k*DATA +: DATA];
                end
            end
            rd[j*ENT +: ENT] = {valid_q[rd_addr[j]] | rd_hit[j],
                                tag_q[rd_addr[j]], rd_byp[j]};
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '1;
            pending <= '0;
            for (int i = 0; i < int'(NREG); i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_n;
            pending <= pending_n;
            for (int i = 0; i < int'(NREG); i++) begin
                tag_q[i]  <= tag_n[i];
                data_q[i] <= data_n[i];
            end
        end
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Self-checking bench for rename_register_file: directed scenarios followed by
// randomized traffic, all checked against an array-based reference model.
module tb_rename_register_file;

    localparam int DATA = 32;
    localparam int ADDR = 5;
    localparam int TAG  = 7;
    localparam int NRD  = 4;
    localparam int NWB  = 2;
    localparam int NREG = 32;
    localparam int ENT  = 1 + TAG + DATA;

    logic                clk;
    logic                rst;
    logic                flush;
    logic                we_d;
    logic [ADDR-1:0]     wa_d;
    logic [TAG-1:0]      tag_d;
    logic [NWB-1:0]      we_w;
    logic [NWB*ADDR-1:0] wa_w;
    logic [NWB*TAG-1:0]  tag_w;
    logic [NWB*DATA-1:0] wd_w;
    logic [NRD*ADDR-1:0] ra;
    logic [NRD*ENT-1:0]  rd;
    logic [ADDR:0]       pending;

    rename_register_file #(
        .DATA(DATA), .ADDR(ADDR), .TAG(TAG), .NRD(NRD), .NWB(NWB)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .we_d(we_d), .wa_d(wa_d), .tag_d(tag_d),
        .we_w(we_w), .wa_w(wa_w), .tag_w(tag_w), .wd_w(wd_w),
        .ra(ra), .rd(rd), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    bit              m_v [NREG];
    logic [TAG-1:0]  m_t [NREG];
    logic [DATA-1:0] m_d [NREG];
    int              m_pend;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic logic [ENT-1:0] mk(input bit v, input logic [TAG-1:0] t, input logic [DATA-1:0] d);
        return {v, t, d};
    endfunction

    // Expected read: stored entry, or the youngest tag-matching commit's data.
    function automatic logic [ENT-1:0] model_read(input int a);
        logic [ENT-1:0] r;
        r = mk(m_v[a], m_t[a], m_d[a]);
        if (a != 0)
            for (int k = 0; k < NWB; k++)
                if (we_w[k] && int'(wa_w[k*ADDR +: ADDR]) == a && tag_w[k*TAG +: TAG] == m_t[a])
                    r = mk(1'b1, m_t[a], wd_w[k*DATA +: DATA]);
        return r;
    endfunction

    task automatic model_update();
        bit              nv [NREG];
        logic [TAG-1:0]  nt [NREG];
        logic [DATA-1:0] nd [NREG];
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_v[i] = 1'b1; m_t[i] = '0; m_d[i] = '0;
            end
            m_pend = 0;
            return;
        end
        nv = m_v; nt = m_t; nd = m_d;
        for (int k = 0; k < NWB; k++) begin
            int a;
            a = int'(wa_w[k*ADDR +: ADDR]);
            if (we_w[k] && a != 0) begin
                nd[a] = wd_w[k*DATA +: DATA];
                if (tag_w[k*TAG +: TAG] == m_t[a]) nv[a] = 1'b1;
            end
        end
        if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                nv[i] = 1'b1; nt[i] = '0;
            end
        end else if (we_d && wa_d != 0) begin
            nv[wa_d] = 1'b0; nt[wa_d] = tag_d;
        end
        m_v = nv; m_t = nt; m_d = nd;
        m_pend = 0;
        for (int i = 1; i < NREG; i++) if (!m_v[i]) m_pend++;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; we_d = 1'b0; wa_d = '0; tag_d = '0;
        we_w = '0; wa_w = '0; tag_w = '0; wd_w = '0;
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2, input int a3);
        ra = {ADDR'(a3), ADDR'(a2), ADDR'(a1), ADDR'(a0)};
    endtask

    task automatic commit(input int k, input int a, input int t, input logic [DATA-1:0] d);
        we_w[k] = 1'b1;
        wa_w[k*ADDR +: ADDR] = ADDR'(a);
        tag_w[k*TAG +: TAG]  = TAG'(t);
        wd_w[k*DATA +: DATA] = d;
    endtask

    task automatic dispatch(input int a, input int t);
        we_d = 1'b1; wa_d = ADDR'(a); tag_d = TAG'(t);
    endtask

    // Mid-cycle: compare every read port and pending against the model.
    task automatic settle();
        @(negedge clk);
        for (int j = 0; j < NRD; j++)
            check($sformatf("rd%0d", j), 64'(rd[j*ENT +: ENT]),
                  64'(model_read(int'(ra[j*ADDR +: ADDR]))));
        check("pending", 64'(pending), 64'(m_pend));
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    function automatic logic [ENT-1:0] port(input int j);
        return rd[j*ENT +: ENT];
    endfunction

    initial begin
        idle();
        set_ra(0, 1, 5, 31);
        // Plan 1: reset, dispatch during reset must be ignored
        rst = 1'b1;
        dispatch(3, 5);
        advance();
        settle();
        check("rst_rd0", 64'(port(0)), 64'(mk(1'b1, 0, 0)));
        check("rst_rd3", 64'(port(3)), 64'(mk(1'b1, 0, 0)));
        check("rst_pend", 64'(pending), 64'd0);
        advance();
        idle(); set_ra(3, 0, 0, 0);
        settle();
        check("rst_r3", 64'(port(0)), 64'(mk(1'b1, 0, 0)));
        advance();

        // Plan 2: rename then commit with matching tag
        set_ra(5, 0, 0, 0);
        dispatch(5, 'h12);
        cyc();
        idle();
        settle();
        check("ren_r5", 64'(port(0)), 64'(mk(1'b0, 'h12, 0)));
        check("ren_pend", 64'(pending), 64'd1);
        advance();
        commit(0, 5, 'h12, 32'hDEADBEEF);
        settle();
        check("byp_r5", 64'(port(0)), 64'(mk(1'b1, 'h12, 32'hDEADBEEF)));
        advance();
        idle();
        settle();
        check("com_r5", 64'(port(0)), 64'(mk(1'b1, 'h12, 32'hDEADBEEF)));
        check("com_pend", 64'(pending), 64'd0);
        advance();

        // Plan 3: stale commit writes data but keeps the younger rename
        set_ra(7, 0, 0, 0);
        dispatch(7, 'h05); cyc();
        dispatch(7, 'h09); cyc();
        idle(); commit(0, 7, 'h05, 32'hA); cyc();
        idle();
        settle();
        check("stale_r7", 64'(port(0)), 64'(mk(1'b0, 'h09, 32'hA)));
        check("stale_pend", 64'(pending), 64'd1);
        advance();
        commit(0, 7, 'h09, 32'hB);
        settle();
        check("young_byp", 64'(port(0)), 64'(mk(1'b1, 'h09, 32'hB)));
        advance();
        idle(); cyc();

        // Plan 4: dispatch and commit to the same register in one cycle
        set_ra(4, 0, 0, 0);
        dispatch(4, 'h11); cyc();
        idle(); dispatch(4, 'h20); commit(0, 4, 'h11, 32'h55);
        settle();
        check("dc_byp", 64'(port(0)), 64'(mk(1'b1, 'h11, 32'h55)));
        advance();
        idle();
        settle();
        check("dc_r4", 64'(port(0)), 64'(mk(1'b0, 'h20, 32'h55)));
        advance();

        // Plan 5: both commit ports on one register; writes to r0
        set_ra(9, 0, 0, 0);
        dispatch(9, 'h33); cyc();
        idle(); commit(0, 9, 'h33, 32'h1); commit(1, 9, 'h33, 32'h2);
        settle();
        check("dual_byp", 64'(port(0)), 64'(mk(1'b1, 'h33, 32'h2)));
        advance();
        idle();
        settle();
        check("dual_r9", 64'(port(0)), 64'(mk(1'b1, 'h33, 32'h2)));
        advance();
        set_ra(0, 0, 0, 0);
        dispatch(0, 'h7F); commit(0, 0, 0, 32'hFFFF); commit(1, 0, 0, 32'h1234);
        settle();
        check("r0_byp", 64'(port(0)), 64'(mk(1'b1, 0, 0)));
        advance();
        idle();
        settle();
        check("r0", 64'(port(0)), 64'(mk(1'b1, 0, 0)));
        advance();

        // Plan 6: flush with concurrent dispatch and commit
        commit(0, 4, 'h20, 32'h0); cyc();
        idle(); dispatch(2, 'h01); cyc();
        dispatch(3, 'h02); cyc();
        dispatch(6, 'h03); cyc();
        idle();
        settle();
        check("pre_flush_pend", 64'(pending), 64'd3);
        advance();
        set_ra(2, 6, 3, 8);
        flush = 1'b1; dispatch(8, 'h44); commit(0, 2, 'h01, 32'h77);
        cyc();
        idle();
        settle();
        check("fl_r2", 64'(port(0)), 64'(mk(1'b1, 0, 32'h77)));
        check("fl_r6", 64'(port(1)), 64'(mk(1'b1, 0, 0)));
        check("fl_r8", 64'(port(3)), 64'(mk(1'b1, 0, 0)));
        check("fl_pend", 64'(pending), 64'd0);
        advance();

        // Randomized traffic, addresses biased to a small window for collisions
        for (int n = 0; n < 3000; n++) begin
            int wide;
            idle();
            wide  = ($urandom_range(0, 3) == 0) ? 31 : 7;
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 1)
                dispatch($urandom_range(0, wide), $urandom_range(0, 127));
            for (int k = 0; k < NWB; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int a;
                    a = $urandom_range(0, wide);
                    commit(k, a, ($urandom_range(0, 2) != 0) ? int'(m_t[a]) : $urandom_range(0, 127),
                           $urandom());
                end
            end
            for (int j = 0; j < NRD; j++)
                ra[j*ADDR +: ADDR] = ADDR'($urandom_range(0, wide));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rename_register_file.md
Name: rename_register_file

Overview:
- Parametrised successor to the ROB-tagged architectural register file. Single clock domain, no half-cycle write split.
- Entry = {valid, ROB tag, data}.
- Each cycle accepts one dispatch rename, NWB commit writes and a flush, and serves NRD source reads with same-cycle commit bypass.
- Sits between decode/dispatch and the reorder buffer. Supplies operand value, or the producing ROB tag, to the issue stage.

Parameters:
- DATA, 32, architectural data width.
- ADDR, 5, register index width; NREG = 2**ADDR entries.
- TAG, 7, ROB tag width.
- NRD, 4, number of read ports.
- NWB, 2, number of commit write ports; higher index = younger commit.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  ROB flush; discard all pending renames.
- we_d  in  1  dispatch rename enable.
- wa_d  in  ADDR  dispatch destination register.
- tag_d  in  TAG  ROB tail tag allocated at dispatch.
- we_w  in  NWB  per-port commit write enable.
- wa_w  in  NWB*ADDR  commit destinations, port k at bits [k*ADDR +: ADDR].
- tag_w  in  NWB*TAG  ROB tag of each committing entry.
- wd_w  in  NWB*DATA  commit data.
- ra  in  NRD*ADDR  read addresses, packed as above.
- rd  out  NRD*(1+TAG+DATA)  per port {valid, tag, data}; valid=1 means data usable, valid=0 means wait on tag.
- pending  out  ADDR+1  count of entries with valid=0.

Behaviour:
- Reset (rst=1 at edge): every entry = {1, 0, 0}; pending = 0. rd therefore shows {1,0,0} for all addresses. Reset overrides flush, dispatch and commit in the same cycle.
- Register 0: never written by dispatch or commit. Always reads {1,0,0}. Not counted in pending.
- Commit port k (we_w[k]=1, wa_w[k]!=0):
  - Data field updated to wd_w[k] unconditionally.
  - valid set to 1 only if the entry's stored tag == tag_w[k]; otherwise valid and tag are left unchanged, because a younger rename is outstanding.
- Multiple commit ports hitting the same register in one cycle: highest-index port wins data. valid is set if any enabled port's tag matches.
- Dispatch (we_d=1, wa_d!=0): entry becomes {0, tag_d, data unchanged}.
- Same cycle, dispatch and commit to the same register: commit data is written; dispatch wins valid/tag, so the result is {0, tag_d, wd}.
- Flush: every entry's valid := 1 and tag := 0; data retained.
  - Commits in the flush cycle still write data.
  - Dispatch in the flush cycle is ignored.
  - pending becomes 0 next cycle.
- Reads are combinational from the current state plus commit bypass:
  - If an enabled commit port targets ra[j] (nonzero) and its tag matches the stored tag, rd[j] = {1, stored tag, wd of the highest such port}.
  - Otherwise rd[j] = stored entry.
  - The dispatch in the same cycle is NOT visible to reads; sources are read before their own destination is renamed.
- pending: registered. Equals the number of nonzero entries with valid=0 after the edge. Updated each cycle from the next-state entries, saturating at NREG-1.
- No handshake back-pressure: the block accepts every request every cycle. Tag uniqueness is the ROB's responsibility.
- Latency: write to state 1 cycle; read 0 cycles, with commit-bypass forwarding inside the same cycle.

Test Plan:
1. Reset, then read ra={0,1,5,31} -> every rd = {1,0,0}; pending=0. Hold rst=1 with we_d=1, wa_d=3 -> entry 3 stays {1,0,0}.
2. Dispatch wa_d=5, tag_d=0x12; next cycle read r5 -> {0,0x12,0}, pending=1. Commit wa_w=5, tag_w=0x12, wd=0xDEADBEEF -> same-cycle rd = {1,0x12,0xDEADBEEF}. Next cycle state = the same value; pending=0.
3. Dispatch r7 with tag 0x05, then r7 with tag 0x09. Commit r7 tag 0x05, data 0xA -> r7 = {0,0x09,0xA}, pending=1. Commit tag 0x09, data 0xB -> {1,0x09,0xB}.
4. Same cycle: dispatch r4 tag 0x20 plus commit r4 with matching old tag and data 0x55 -> r4 = {0,0x20,0x55}. The same-cycle read of r4 shows {1,old tag,0x55}.
5. Both commit ports to r9, port0 data 0x1, port1 data 0x2, both tags matching -> r9 = {1,tag,0x2}. Commits or dispatch to r0 leave r0 = {1,0,0}.
6. Rename r2, r3, r6 (pending=3), then flush together with dispatch r8 and commit r2 data 0x77 -> all entries valid=1, tag=0, r2 data=0x77, r8 unchanged, pending=0.
